mem_512x8_fifo_ctrl: RTL and testbench
======================================

# mem_512x8_fifo_ctrl

Controller that turns the dual-port 512x8 memory logical tile into a synchronous FIFO with valid/ready handshakes. It drives the memory tile's write port (`waddr`, `data_in`, `wen`) and read port (`raddr`, `ren`), and consumes its `data_out`. It sits between fabric-side producer/consumer logic and the memory tile. It is the standard front end for any design that maps a queue onto the memory tile.

## Interface
Parameters:
- `DEPTH`, 512, total FIFO capacity in entries, equal to the memory depth.
- `ADDR_W`, 9, memory address width.
- `DATA_W`, 8, data width.
- `AFULL_LVL`, 496, `almost_full` threshold.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  sole clock; also drives the memory tile clock.
- `reset`  in  1  asynchronous, active-high reset.
- `push_valid`  in  1  producer has data.
- `push_ready`  out  1  FIFO accepts data.
- `push_data`  in  DATA_W  write data.
- `pop_valid`  out  1  `pop_data` is valid.
- `pop_ready`  in  1  consumer takes data.
- `pop_data`  out  DATA_W  head entry, wired straight from `mem_data_out`.
- `count`  out  ADDR_W+1  entries held (0..512).
- `almost_full`  out  1  high when `count >= AFULL_LVL`.
- `err_overflow`  out  1  sticky; push attempted while `push_ready` is low.
- `err_underflow`  out  1  sticky; pop attempted while `pop_valid` is low.
- `mem_waddr`  out  ADDR_W  to memory `waddr`.
- `mem_raddr`  out  ADDR_W  to memory `raddr`.
- `mem_data_in`  out  DATA_W  to memory `data_in`.
- `mem_wen`  out  1  to memory `wen`.
- `mem_ren`  out  1  to memory `ren`.
- `mem_data_out`  in  DATA_W  from memory `data_out`.

## Operation
- Handshake events:
  - push fire = `push_valid && push_ready`.
  - pop fire = `pop_valid && pop_ready`.
- Write path:
  - `mem_wen` = push fire.
  - `mem_waddr` = `wptr`.
  - `mem_data_in` = `push_data`.
  - `wptr` increments modulo 512 on push fire.
- Memory model this block relies on:
  - Synchronous read, one-cycle latency.
  - `mem_data_out` holds its last value while `ren` is low.
- Read prefetch:
  - `mem_cnt = wptr_ext - rptr_ext`, using 10-bit extended pointers.
  - `mem_ren` = `mem_cnt != 0 && (!out_valid || pop fire)`.
  - `mem_raddr` = `rptr`; `rptr` increments on `mem_ren`.
- Output register `out_valid` (drives `pop_valid`):
  - Set to 1 on `mem_ren`.
  - Otherwise cleared on pop fire.
  - Otherwise holds.
- Occupancy:
  - `count = mem_cnt + out_valid`.
  - `push_ready = (count < DEPTH)`.
- Pointer wrap: address 511 is followed by 0. Full and empty are distinguished by bit 9 of the extended pointers.
- Collision freedom:
  - A read is issued only when `mem_cnt > 0`.
  - While an entry is held at the output, `mem_cnt <= 511`.
  - Therefore `raddr != waddr` whenever both ports are active. No read-during-write hazard exists.
- Simultaneous push and pop at full: `push_ready` is computed from the registered `count`, so the push is refused that cycle. There is no combinational path from `pop_ready` to `push_ready`.
- Simultaneous push and pop when `count == 1`:
  - Pop drains the output register.
  - The new entry is written to memory.
  - `count` stays 1 after two cycles, with one cycle of `pop_valid` low in between.

## Timing
- Reset values:
  - `wptr`, `rptr`, `count` = 0.
  - `pop_valid`, `almost_full`, `err_*` = 0.
  - `push_ready` = 1.
  - `mem_wen`, `mem_ren` = 0.
- Reset mid-operation: all state clears asynchronously. Memory contents are not cleared but are unreachable afterwards.
- Latency from a push into an empty FIFO to `pop_valid`: 2 cycles.
  - Write at edge E0.
  - Read issued in the cycle after E0, captured at E1.
  - `pop_valid` high after E1.
- Steady-state throughput: 1 push and 1 pop per cycle.
- `count` and `almost_full` are registered and update at the edge that commits the event.

## Configuration
- `MEM_FIFO_CTRL_ERR_EN` defined:
  - `err_overflow` and `err_underflow` are sticky flags, set on the illegal attempt.
  - They are cleared only by `reset`.
- `MEM_FIFO_CTRL_ERR_EN` undefined:
  - Both ports remain present, tied to 0.
  - No error logic is generated.

## Structure
- Package `mem_fifo_pkg`: `ADDR_W`, `DATA_W`, `DEPTH`, `AFULL_LVL` defaults, and a `cnt_t` typedef (ADDR_W+1 bits).
- Sub-module `mem_fifo_ptr`: extended pointer with increment enable and async reset. Instantiated twice, once for write and once for read.

## Test plan
- Reset, then push 0x5A once → `mem_wen=1` with `mem_waddr=0`; `pop_valid` high 2 cycles later with `pop_data=0x5A`; `count=1`.
- Push 512 entries (0x00..0xFF twice) with `pop_ready=0` → `push_ready=0` and `count=512`; `almost_full` asserts at `count=496`. Drain all → data returned in order and `count=0`.
- Continuous push and pop for 2000 cycles → one transfer per cycle, pointers wrap past 511, no data loss, `count` constant.
- With the macro defined: push while full → `err_overflow=1` and sticky; pop while empty → `err_underflow=1`. Without the macro: both stay 0.
- Assert `reset` with 100 entries held → next cycle `count=0`, `pop_valid=0`, `push_ready=1`. A subsequent push of 0x33 is read back as 0x33.
- Push and pop in the same cycle with `count=1` → first entry delivered, new entry becomes visible 2 cycles later, `count` never exceeds 2.

Source files
------------

// File: rtl/mem_fifo_pkg.sv
// Shared defaults for the 512x8 memory-tile FIFO controller.
// Holds the parameter defaults and the occupancy type used by the controller.
package mem_fifo_pkg;

  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEPTH     = 512;
  localparam int unsigned AFULL_LVL = 496;

  // Occupancy / extended-pointer type: one bit wider than the address.
  typedef logic [ADDR_W:0] cnt_t;

endpackage

// File: rtl/mem_fifo_ptr.sv
// Extended FIFO pointer: wraps modulo 2^W, advances by one when inc is high.
// Ports:
//   clk, reset (async, active-high)
//   inc  - advance the pointer this cycle
//   ptr  - current extended pointer (MSB is the wrap bit)
module mem_fifo_ptr #(
  parameter int unsigned W = mem_fifo_pkg::ADDR_W + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mem_512x8_fifo_ctrl.sv
// Valid/ready FIFO controller for the dual-port 512x8 memory tile.
// The tile holds the queue body; a one-entry output register holds the head,
// refilled by a one-cycle-latency synchronous read (prefetch).
// Ports:
//   clk, reset (async, active-high)
//   push_valid/push_ready/push_data  - producer side
//   pop_valid/pop_ready/pop_data     - consumer side (pop_data = mem_data_out)
//   count, almost_full               - registered occupancy and threshold flag
//   err_overflow, err_underflow      - sticky illegal-attempt flags
//   mem_waddr/mem_data_in/mem_wen    - tile write port
//   mem_raddr/mem_ren/mem_data_out   - tile read port
// Build option: define MEM_FIFO_CTRL_ERR_EN to generate the sticky error
// flags; otherwise both error outputs are tied to 0.
module mem_512x8_fifo_ctrl
  import mem_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = mem_fifo_pkg::DEPTH,
  parameter int unsigned ADDR_W    = mem_fifo_pkg::ADDR_W,
  parameter int unsigned DATA_W    = mem_fifo_pkg::DATA_W,
  parameter int unsigned AFULL_LVL = mem_fifo_pkg::AFULL_LVL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              err_overflow,
  output logic              err_underflow,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_wen,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int unsigned CW = ADDR_W + 1;

  logic [CW-1:0] wptr_ext;
  logic [CW-1:0] rptr_ext;
  logic [CW-1:0] mem_cnt;
  logic          push_fire;
  logic          pop_fire;
  logic          rd_issue;

  logic [CW-1:0] count_q,       count_d;
  logic          out_valid_q,   out_valid_d;
  logic          almost_full_q, almost_full_d;

  mem_fifo_ptr #(.W(CW)) u_wptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push_fire),
    .ptr   (wptr_ext)
  );

  mem_fifo_ptr #(.W(CW)) u_rptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_issue),
    .ptr   (rptr_ext)
  );

  // Handshakes; push_ready comes only from the registered count, so there is
  // no combinational pop_ready -> push_ready path.
  assign push_ready = (count_q < CW'(DEPTH));
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = out_valid_q && pop_ready;

  // Entries still in the tile; the wrap bit separates full from empty.
  assign mem_cnt  = wptr_ext - rptr_ext;
  // Prefetch whenever the head slot is empty or being drained this cycle.
  assign rd_issue = (mem_cnt != '0) && (!out_valid_q || pop_fire);

  // Next-state for the head register and occupancy.
  always_comb begin
    out_valid_d   = out_valid_q;
    count_d       = count_q;
    almost_full_d = almost_full_q;
    if (rd_issue)      out_valid_d = 1'b1;
    else if (pop_fire) out_valid_d = 1'b0;
    count_d       = count_q + CW'(push_fire) - CW'(pop_fire);
    almost_full_d = (count_d >= CW'(AFULL_LVL));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
    end
  end

`ifdef MEM_FIFO_CTRL_ERR_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;

  // Sticky flags, cleared only by reset.
  always_comb begin
    err_ovf_d = err_ovf_q;
    err_udf_d = err_udf_q;
    if (push_valid && !push_ready) err_ovf_d = 1'b1;
    if (pop_ready && !out_valid_q) err_udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_udf_q;
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

  assign pop_valid   = out_valid_q;
  assign pop_data    = mem_data_out;
  assign count       = count_q;
  assign almost_full = almost_full_q;

  assign mem_wen     = push_fire;
  assign mem_waddr   = wptr_ext[ADDR_W-1:0];
  assign mem_data_in = push_data;
  assign mem_ren     = rd_issue;
  assign mem_raddr   = rptr_ext[ADDR_W-1:0];

endmodule

// File: tb/tb_mem_512x8_fifo_ctrl.sv
// Directed bench for mem_512x8_fifo_ctrl with a behavioural 512x8 tile model.
module tb_mem_512x8_fifo_ctrl;

`ifdef MEM_FIFO_CTRL_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push_valid = 1'b0;
  logic       push_ready;
  logic [7:0] push_data = '0;
  logic       pop_valid;
  logic       pop_ready = 1'b0;
  logic [7:0] pop_data;
  logic [9:0] count;
  logic       almost_full;
  logic       err_overflow;
  logic       err_underflow;
  logic [8:0] mem_waddr;
  logic [8:0] mem_raddr;
  logic [7:0] mem_data_in;
  logic       mem_wen;
  logic       mem_ren;
  logic [7:0] mem_data_out = '0;

  logic [7:0] mem [512];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_512x8_fifo_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .push_data     (push_data),
    .pop_valid     (pop_valid),
    .pop_ready     (pop_ready),
    .pop_data      (pop_data),
    .count         (count),
    .almost_full   (almost_full),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .mem_waddr     (mem_waddr),
    .mem_raddr     (mem_raddr),
    .mem_data_in   (mem_data_in),
    .mem_wen       (mem_wen),
    .mem_ren       (mem_ren),
    .mem_data_out  (mem_data_out)
  );

  // Tile model: synchronous write, synchronous read that holds while ren low.
  always @(posedge clk) begin
    if (mem_wen) mem[mem_waddr] <= mem_data_in;
    if (mem_ren) mem_data_out <= mem[mem_raddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gen(input int k);
    return 8'(k * 7 + 3);
  endfunction

  // Wait (bounded) for a valid head, check it, then take it.
  task automatic pop_one(input logic [7:0] exp);
    int n = 0;
    while (!pop_valid && n < 8) begin
      tick();
      n++;
    end
    check("pop_wait", {31'd0, pop_valid}, 32'd1);
    if (pop_valid) begin
      check("pop_data", {24'd0, pop_data}, {24'd0, exp});
      pop_ready = 1'b1;
      tick();
      pop_ready = 1'b0;
    end
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_count", {22'd0, count}, 32'd0);
    check("rst_pop_valid", {31'd0, pop_valid}, 32'd0);
    check("rst_push_ready", {31'd0, push_ready}, 32'd1);
    check("rst_afull", {31'd0, almost_full}, 32'd0);
    check("rst_ren", {31'd0, mem_ren}, 32'd0);
    check("rst_wen", {31'd0, mem_wen}, 32'd0);
    check("rst_errs", {30'd0, err_overflow, err_underflow}, 32'd0);

    // Single push, two-cycle latency
    push_valid = 1'b1;
    push_data  = 8'h5A;
    #1;
    check("t1_wen", {31'd0, mem_wen}, 32'd1);
    check("t1_waddr", {23'd0, mem_waddr}, 32'd0);
    tick();
    push_valid = 1'b0;
    check("t1_count_e0", {22'd0, count}, 32'd1);
    check("t1_pv_e0", {31'd0, pop_valid}, 32'd0);
    check("t1_ren", {31'd0, mem_ren}, 32'd1);
    check("t1_raddr", {23'd0, mem_raddr}, 32'd0);
    tick();
    check("t1_pv_e1", {31'd0, pop_valid}, 32'd1);
    check("t1_data", {24'd0, pop_data}, 32'h5A);
    check("t1_count_e1", {22'd0, count}, 32'd1);
    pop_one(8'h5A);
    check("t1_count_end", {22'd0, count}, 32'd0);

    // Fill to 512 with no pops
    for (int i = 0; i < 512; i++) begin
      push_valid = 1'b1;
      push_data  = 8'(i);
      tick();
      if (i == 494) check("af_495", {31'd0, almost_full}, 32'd0);
      if (i == 495) check("af_496", {31'd0, almost_full}, 32'd1);
    end
    push_valid = 1'b0;
    check("full_count", {22'd0, count}, 32'd512);
    check("full_ready", {31'd0, push_ready}, 32'd0);
    check("full_af", {31'd0, almost_full}, 32'd1);

    // Push while full: refused, flag if enabled
    push_valid = 1'b1;
    push_data  = 8'hEE;
    #1;
    check("ovf_wen", {31'd0, mem_wen}, 32'd0);
    tick();
    push_valid = 1'b0;
    tick();
    check("ovf_flag", {31'd0, err_overflow}, {31'd0, ERR_EN});
    check("ovf_count", {22'd0, count}, 32'd512);

    // Drain in order
    for (int i = 0; i < 512; i++) pop_one(8'(i));
    check("drain_count", {22'd0, count}, 32'd0);
    check("drain_pv", {31'd0, pop_valid}, 32'd0);
    check("drain_af", {31'd0, almost_full}, 32'd0);
    check("udf_pre", {31'd0, err_underflow}, 32'd0);

    // Pop while empty
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
    check("udf_flag", {31'd0, err_underflow}, {31'd0, ERR_EN});
    check("ovf_sticky", {31'd0, err_overflow}, {31'd0, ERR_EN});

    // Continuous push/pop with two entries in flight
    push_valid = 1'b1;
    push_data  = gen(0);
    tick();
    push_data  = gen(1);
    tick();
    push_valid = 1'b0;
    check("str_pv", {31'd0, pop_valid}, 32'd1);
    check("str_count0", {22'd0, count}, 32'd2);
    for (int k = 2; k < 2002; k++) begin
      push_valid = 1'b1;
      push_data  = gen(k);
      pop_ready  = 1'b1;
      #1;
      check("str_pv", {31'd0, pop_valid}, 32'd1);
      check("str_data", {24'd0, pop_data}, {24'd0, gen(k - 2)});
      tick();
      check("str_count", {22'd0, count}, 32'd2);
    end
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    pop_one(gen(2000));
    pop_one(gen(2001));
    check("str_end", {22'd0, count}, 32'd0);

    // Reset with 100 entries held
    for (int i = 0; i < 100; i++) begin
      push_valid = 1'b1;
      push_data  = 8'(i + 100);
      tick();
    end
    push_valid = 1'b0;
    check("r100_count", {22'd0, count}, 32'd100);
    reset = 1'b1;
    #1;
    check("rasync_count", {22'd0, count}, 32'd0);
    tick();
    reset = 1'b0;
    check("rmid_count", {22'd0, count}, 32'd0);
    check("rmid_pv", {31'd0, pop_valid}, 32'd0);
    check("rmid_ready", {31'd0, push_ready}, 32'd1);
    check("rmid_errs", {30'd0, err_overflow, err_underflow}, 32'd0);
    push_valid = 1'b1;
    push_data  = 8'h33;
    #1;
    check("rmid_waddr", {23'd0, mem_waddr}, 32'd0);
    tick();
    push_valid = 1'b0;
    pop_one(8'h33);

    // Simultaneous push and pop at count==1
    push_valid = 1'b1;
    push_data  = 8'h11;
    tick();
    push_valid = 1'b0;
    tick();
    check("c1_pv", {31'd0, pop_valid}, 32'd1);
    check("c1_count", {22'd0, count}, 32'd1);
    push_valid = 1'b1;
    push_data  = 8'h22;
    pop_ready  = 1'b1;
    #1;
    check("c1_head", {24'd0, pop_data}, 32'h11);
    check("c1_ren", {31'd0, mem_ren}, 32'd0);
    check("c1_wen", {31'd0, mem_wen}, 32'd1);
    tick();
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    check("c1_gap_pv", {31'd0, pop_valid}, 32'd0);
    check("c1_gap_count", {22'd0, count}, 32'd1);
    tick();
    check("c1_new_pv", {31'd0, pop_valid}, 32'd1);
    check("c1_new_data", {24'd0, pop_data}, 32'h22);
    check("c1_new_count", {22'd0, count}, 32'd1);
    pop_one(8'h22);
    check("final_count", {22'd0, count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
